// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, status and baud divisor registers.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit to every frame.

// Generic synchronous FIFO with extended pointers.
// Latency: a pushed entry is visible on out_dat the cycle after the push.
// Backpressure: in_rdy drops when full; a push while full is still taken if a pop happens the same cycle.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_vld,
    input  logic [WIDTH-1:0]       in_dat,
    output logic                   in_rdy,
    output logic                   out_vld,
    output logic [WIDTH-1:0]       out_dat,
    input  logic                   out_rdy,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap bits means the FIFO holds DEPTH entries.
    assign out_vld = (wr_ptr != rd_ptr);
    assign in_rdy  = !((wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]));
    assign do_pop  = out_vld && out_rdy;
    assign do_push = in_vld && (in_rdy || do_pop);
    assign out_dat = mem[rd_ptr[AW-1:0]];
    assign count   = wr_ptr - rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= in_dat;
    end
endmodule

// UART TX peripheral on the data-memory bus: TXDATA / STATUS / BAUD registers.
// Latency: a TXDATA write on edge N starts the frame (tx falls) on edge N+1 when idle.
// Backpressure: none on the bus; pushes into a full FIFO are dropped and flagged in STATUS.overflow.
module uart_tx_periph #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [3:0]  sel,
    input  logic [31:0] wraddr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        tx_irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_FLAG = 1'b1;
`else
    localparam logic PAR_FLAG = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state;
    logic [15:0]   div;
    logic [15:0]   div_lat;
    logic [15:0]   baud_cnt;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;
    logic          ovf;
`ifdef UART_TX_PARITY_EN
    logic          par_bit;
`endif

    logic          wr_txdata;
    logic          wr_status;
    logic          wr_baud;
    logic          fifo_in_rdy;
    logic          fifo_out_vld;
    logic [7:0]    fifo_out_dat;
    logic [CW-1:0] fifo_count;
    logic          pop;
    logic          busy;
    logic [31:0]   status;
    logic          unused_bits;

    assign wr_txdata = ce && we && sel[0] && (wraddr[3:2] == 2'd0);
    assign wr_status = ce && we && (wraddr[3:2] == 2'd1);
    assign wr_baud   = ce && we && (wraddr[3:2] == 2'd2);
    assign pop       = (state == IDLE) && fifo_out_vld;
    assign busy      = (state != IDLE);
    assign tx_irq    = !fifo_out_vld && !busy;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (wr_txdata),
        .in_dat  (wdata[7:0]),
        .in_rdy  (fifo_in_rdy),
        .out_vld (fifo_out_vld),
        .out_dat (fifo_out_dat),
        .out_rdy (pop),
        .count   (fifo_count)
    );

    assign status = {16'h0, 8'(fifo_count), 3'b000, PAR_FLAG, ovf,
                     !fifo_out_vld, !fifo_in_rdy, busy};

    always_comb begin
        rdata = 32'h0;
        if (ce) begin
            case (wraddr[3:2])
                2'd1:    rdata = status;
                2'd2:    rdata = {16'h0, div};
                default: rdata = 32'h0;
            endcase
        end
    end

    // A drop only happens when full and the serializer is not popping this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= DEFAULT_DIV;
            ovf <= 1'b0;
        end else begin
            if (wr_baud && sel[0]) div[7:0]  <= wdata[7:0];
            if (wr_baud && sel[1]) div[15:8] <= wdata[15:8];
            if (wr_txdata && !fifo_in_rdy && !pop)
                ovf <= 1'b1;
            else if (wr_status && sel[0] && wdata[3])
                ovf <= 1'b0;
        end
    end

    // Divisor is latched at pop so BAUD writes only affect the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            shreg    <= 8'h0;
            bit_idx  <= 3'd0;
            baud_cnt <= 16'h0;
            div_lat  <= 16'h0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (fifo_out_vld) begin
                        shreg    <= fifo_out_dat;
                        div_lat  <= div;
                        baud_cnt <= div;
                        bit_idx  <= 3'd0;
                        tx       <= 1'b0;
                        state    <= START;
`ifdef UART_TX_PARITY_EN
                        par_bit  <= ^fifo_out_dat;
`endif
                    end
                end
                START: begin
                    if (baud_cnt == 16'h0) begin
                        baud_cnt <= div_lat;
                        tx       <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt == 16'h0) begin
                        baud_cnt <= div_lat;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= par_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_cnt == 16'h0) begin
                        baud_cnt <= div_lat;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
`endif
                STOP: begin
                    tx <= 1'b1;
                    if (baud_cnt == 16'h0)
                        state <= IDLE;
                    else
                        baud_cnt <= baud_cnt - 16'd1;
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign unused_bits = ^{wraddr[31:4], wraddr[1:0], wdata[31:16], sel[3:2]};
endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: directed steps plus randomized pushes, with a frame-level line monitor.
module tb_uart_tx_periph;
`ifdef UART_TX_PARITY_EN
    localparam int          NB  = 11;
    localparam logic [31:0] PAR = 32'h10;
`else
    localparam int          NB  = 10;
    localparam logic [31:0] PAR = 32'h0;
`endif

    logic        clk;
    logic        rst;
    logic        ce;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wraddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx;
    logic        tx_irq;

    int          tests = 0;
    int          fails = 0;
    int          model_div = 867;
    logic [7:0]  exp_q[$];

    uart_tx_periph dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .we     (we),
        .sel    (sel),
        .wraddr (wraddr),
        .wdata  (wdata),
        .rdata  (rdata),
        .tx     (tx),
        .tx_irq (tx_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Line monitor: each frame must match the next expected byte, cycle by cycle.
    bit          mon_in = 1'b0;
    int          mon_cyc, mon_p, mon_err;
    logic [10:0] mon_bits;
    logic [7:0]  mon_byte;

    always @(negedge clk) begin
        if (rst) begin
            mon_in = 1'b0;
        end else if (!mon_in) begin
            if (tx === 1'b0) begin
                check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_byte = exp_q.pop_front();
                    mon_bits = '1;
                    mon_bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) mon_bits[1+i] = mon_byte[i];
`ifdef UART_TX_PARITY_EN
                    mon_bits[9] = ^mon_byte;
`endif
                    mon_p   = model_div + 1;
                    mon_cyc = 1;
                    mon_err = 0;
                    mon_in  = 1'b1;
                end
            end
        end else begin
            if (tx !== mon_bits[mon_cyc / mon_p]) mon_err++;
            mon_cyc++;
            if (mon_cyc == NB * mon_p) begin
                mon_in = 1'b0;
                check($sformatf("frame_%02h_bits", mon_byte), mon_err, 0);
            end
        end
    end

    // Bus tasks are entered just after a falling edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] s, input logic c);
        ce = c; we = 1'b1; sel = s; wraddr = addr; wdata = data;
        @(negedge clk);
        ce = 1'b0; we = 1'b0; sel = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] d);
        ce = 1'b1; we = 1'b0; sel = 4'h0; wraddr = addr;
        #1 d = rdata;
        ce = 1'b0;
    endtask

    task automatic set_baud(input int d);
        bus_write(32'h8, 32'(d), 4'b0011, 1'b1);
        model_div = d;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (!(tx_irq === 1'b1 && !mon_in) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("idle_within_budget", 32'(k < budget), 32'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] r;
        logic [10:0] obs;
        logic [3:0]  s;
        logic        c;
        logic [7:0]  b;
        int          j;
        int          lows;

        rst = 1'b1; ce = 1'b0; we = 1'b0; sel = 4'h0; wraddr = 32'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_irq", 32'(tx_irq), 32'd1);
        bus_read(32'h4, d);
        check("rst_status", d, 32'h4 | PAR);
        #2 rst = 1'b0;
        @(negedge clk);
        bus_read(32'h8, d);
        check("rst_baud", d, 32'd867);
        ce = 1'b0; wraddr = 32'h4;
        #1 check("rdata_ce0", rdata, 32'h0);

        // BAUD=3, send 0xA5 with exact edge timing
        set_baud(3);
        exp_q.push_back(8'hA5);
        bus_write(32'h0, 32'h0000_00A5, 4'b0001, 1'b1);
        check("tx_after_push", 32'(tx), 32'd1);
        bus_read(32'h4, d);
        check("status_after_push", d, 32'h100 | PAR);
        @(negedge clk);
        check("tx_falls_next", 32'(tx), 32'd0);
        bus_read(32'h4, d);
        check("status_in_frame", d, 32'h5 | PAR);
        bus_read(32'h0, d);
        check("txdata_reads_0", d, 32'h0);
        j = 0; obs = '0;
        while (tx_irq !== 1'b1 && j < 1000) begin
            if (j % 4 == 2 && j / 4 < NB) obs[j/4] = tx;
            @(negedge clk);
            j++;
        end
        check("a5_frame_len", j, NB * 4);
`ifdef UART_TX_PARITY_EN
        check("a5_bits", 32'(obs), 32'h54A);
`else
        check("a5_bits", 32'(obs[9:0]), 32'h34A);
`endif
        check("tx_idle_after", 32'(tx), 32'd1);

        // writes without sel[0] or ce must not push
        bus_write(32'h0, 32'h0000_0055, 4'b1110, 1'b1);
        bus_write(32'h0, 32'h0000_0066, 4'b0001, 1'b0);
        bus_read(32'h4, d);
        check("no_push_status", d, 32'h4 | PAR);

        // byte lanes of BAUD
        bus_write(32'h8, 32'hFFFF_05EE, 4'b0010, 1'b1);
        bus_read(32'h8, d);
        check("baud_lane1", d, 32'h0000_0503);
        set_baud(3);
        bus_write(32'hC, 32'hFFFF_FFFF, 4'b1111, 1'b1);
        bus_read(32'hC, d);
        check("reg3_reads_0", d, 32'h0);

        // overflow: 9 consecutive pushes fit, the tenth is dropped
        set_baud(0);
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(8'(8'h30 + i));
            bus_write(32'h0, 32'(8'h30 + i), 4'b0001, 1'b1);
        end
        bus_read(32'h4, d);
        check("nine_pushes_status", d, 32'h0803 | PAR);
        bus_write(32'h0, 32'h0000_00EE, 4'b0001, 1'b1);
        bus_read(32'h4, d);
        check("overflow_set", d, 32'h080B | PAR);
        bus_write(32'h4, 32'h0000_0008, 4'b0001, 1'b1);
        bus_read(32'h4, d);
        check("overflow_cleared", d, 32'h0803 | PAR);
        wait_idle(2000);
        check("overflow_all_sent", exp_q.size(), 0);

        // BAUD change mid-frame only affects the next frame
        set_baud(3);
        exp_q.push_back(8'h5A);
        bus_write(32'h0, 32'h0000_005A, 4'b0001, 1'b1);
        exp_q.push_back(8'hC3);
        bus_write(32'h0, 32'h0000_00C3, 4'b0001, 1'b1);
        j = 0;
        while (!(mon_in && mon_cyc >= 6) && j < 200) begin @(negedge clk); j++; end
        set_baud(7);
        j = 0;
        while (mon_in && j < 200) begin @(negedge clk); j++; end
        j = 0;
        while (tx !== 1'b0 && j < 20) begin @(negedge clk); j++; end
        check("second_frame_gap", j, 1);
        j = 0;
        while (tx_irq !== 1'b1 && j < 1000) begin @(negedge clk); j++; end
        check("second_frame_len", j, NB * 8);
        bus_read(32'h8, d);
        check("baud_readback", d, 32'd7);

        // reset during DATA discards the frame and the queued byte
        set_baud(3);
        exp_q.push_back(8'h3C);
        bus_write(32'h0, 32'h0000_003C, 4'b0001, 1'b1);
        exp_q.push_back(8'h81);
        bus_write(32'h0, 32'h0000_0081, 4'b0001, 1'b1);
        j = 0;
        while (!(mon_in && mon_cyc >= 8) && j < 200) begin @(negedge clk); j++; end
        check("reached_data", 32'(j < 200), 32'd1);
        #2 rst = 1'b1;
        #1 check("tx_async_reset", 32'(tx), 32'd1);
        exp_q.delete();
        model_div = 867;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        bus_read(32'h4, d);
        check("status_after_reset", d, 32'h4 | PAR);
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("no_frames_after_reset", lows, 0);

        // randomized pushes with random lanes/ce and address junk
        for (int it = 0; it < 8; it++) begin
            set_baud($urandom_range(0, 5));
            for (int n = 0; n < int'($urandom_range(1, 4)); n++) begin
                r = $urandom;
                b = 8'($urandom);
                c = ($urandom_range(0, 4) != 0);
                s = 4'($urandom);
                if (c && s[0]) exp_q.push_back(b);
                bus_write({r[31:4], 2'b00, r[1:0]}, {r[23:0], b}, s, c);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            wait_idle(3000);
            bus_read(32'h4, d);
            check("rand_status_idle", d, 32'h4 | PAR);
            bus_read(32'h8, d);
            check("rand_baud", d, 32'(model_div));
        end
        check("all_frames_seen", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
